// File: rtl/regfile_sched_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// The bypass feature (WB_BYPASS_EN) is configured in the interface and the top.
package regfile_sched_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_idx_t;

  // Requester identity; also the encoding of the round-robin pointer.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// Issue, writeback-request and register-file write bundle of the scheduler.
// Optional byp1/byp2 signals exist only when WB_BYPASS_EN is defined.
interface regfile_wb_scheduler_if;
  import regfile_sched_pkg::*;

  logic                issue_valid;
  reg_idx_t            issue_rd;
  reg_idx_t            rs1;
  reg_idx_t            rs2;
  logic                stall;

  logic                alu_valid;
  reg_idx_t            alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                alu_ready;

  logic                mem_valid;
  reg_idx_t            mem_rd;
  logic [XLEN-1:0]     mem_data;
  logic                mem_ready;

  logic                regwrite;
  reg_idx_t            rd;
  logic [XLEN-1:0]     wd3;
  logic [NUM_REGS-1:0] busy;

`ifdef WB_BYPASS_EN
  logic                byp1;
  logic                byp2;
`endif

  modport slave (
`ifdef WB_BYPASS_EN
    output byp1, byp2,
`endif
    input  issue_valid, issue_rd, rs1, rs2,
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    output stall, alu_ready, mem_ready,
    output regwrite, rd, wd3, busy
  );

  modport master (
`ifdef WB_BYPASS_EN
    input  byp1, byp2,
`endif
    output issue_valid, issue_rd, rs1, rs2,
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    input  stall, alu_ready, mem_ready,
    input  regwrite, rd, wd3, busy
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; req/gnt bit 0 is ALU, bit 1 is MEM.
// The pointer names the favoured side and moves only when a grant is issued.
module rr_arbiter2
  import regfile_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  wb_src_e ptr_q, ptr_d;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr_q == WB_ALU) ? 2'b01 : 2'b10;
    end
  end

  // Grant implies valid, so every grant is a transfer.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0]) begin
      ptr_d = WB_MEM;
    end else if (gnt[1]) begin
      ptr_d = WB_ALU;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= WB_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port owner: round-robin writeback arbitration, registered
// write stage and pending-write scoreboard. Optional feature macro: WB_BYPASS_EN.
module regfile_wb_scheduler
  import regfile_sched_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  regfile_wb_scheduler_if.slave  bus
);

  logic [1:0]          req;
  logic [1:0]          gnt;
  reg_idx_t            sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic                xfer;

  logic                regwrite_q, regwrite_d;
  reg_idx_t            rd_q, rd_d;
  logic [XLEN-1:0]     wd3_q, wd3_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;

  logic                haz_rs1;
  logic                haz_rs2;
  logic                stall;

  assign req = {bus.mem_valid, bus.alu_valid};

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .gnt (gnt)
  );

  assign bus.alu_ready = gnt[0];
  assign bus.mem_ready = gnt[1];

  assign xfer     = |gnt;
  assign sel_rd   = gnt[1] ? bus.mem_rd   : bus.alu_rd;
  assign sel_data = gnt[1] ? bus.mem_data : bus.alu_data;

  // x0 transfers are accepted but never reach the register file.
  always_comb begin
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wd3_d      = wd3_q;
    if (xfer && (sel_rd != '0)) begin
      regwrite_d = 1'b1;
      rd_d       = sel_rd;
      wd3_d      = sel_data;
    end
  end

`ifdef WB_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1 = regwrite_q && (rd_q != '0) && (rd_q == bus.rs1);
  assign byp2 = regwrite_q && (rd_q != '0) && (rd_q == bus.rs2);
  assign bus.byp1 = byp1;
  assign bus.byp2 = byp2;

  // A source being written this cycle is forwarded from wd3, so it needs no stall.
  assign haz_rs1 = busy_q[bus.rs1] && !byp1;
  assign haz_rs2 = busy_q[bus.rs2] && !byp2;
`else
  assign haz_rs1 = busy_q[bus.rs1];
  assign haz_rs2 = busy_q[bus.rs2];
`endif

  assign stall     = bus.issue_valid && (haz_rs1 || haz_rs2 || busy_q[bus.issue_rd]);
  assign bus.stall = stall;

  // Clear first so an issue to the same register in the same cycle wins.
  always_comb begin
    busy_d = busy_q;
    if (regwrite_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (bus.issue_valid && !stall && (bus.issue_rd != '0)) begin
      busy_d[bus.issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wd3_q      <= '0;
      busy_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wd3_q      <= wd3_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.regwrite = regwrite_q;
  assign bus.rd       = rd_q;
  assign bus.wd3      = wd3_q;
  assign bus.busy     = busy_q;

endmodule
